// File: rtl/fwd_sel_gen.sv
// Forwarding-control unit: tracks destination tags of instructions in EX and MEM,
// produces registered EX operand-mux selects and a combinational load-use hazard flag.
module fwd_sel_gen #(
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              stall,
  input  logic              flush,
  output logic [SEL_W-1:0]  sel_a,
  output logic [SEL_W-1:0]  sel_b,
  output logic              load_use_hazard
);

  localparam logic [SEL_W-1:0] SEL_RF  = '0;
  localparam logic [SEL_W-1:0] SEL_MEM = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_EX  = SEL_W'(2);

  // WB tags are never forwarded (register file is write-through), so the tag pipe ends at MEM.
  logic              ex_valid_q, ex_valid_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              ex_rw_q, ex_rw_d;
  logic              ex_mr_q, ex_mr_d;
  logic              mem_valid_q, mem_valid_d;
  logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
  logic              mem_rw_q, mem_rw_d;
  logic [SEL_W-1:0]  sel_a_q, sel_a_d;
  logic [SEL_W-1:0]  sel_b_q, sel_b_d;

  logic ex_writes_any, mem_writes_any;
  logic ex_wr_a, ex_wr_b, mem_wr_a, mem_wr_b;

  assign ex_writes_any  = ex_valid_q & ex_rw_q & (ex_rd_q != '0);
  assign mem_writes_any = mem_valid_q & mem_rw_q & (mem_rd_q != '0);
  assign ex_wr_a  = ex_writes_any & (ex_rd_q == id_rs1);
  assign ex_wr_b  = ex_writes_any & (ex_rd_q == id_rs2);
  assign mem_wr_a = mem_writes_any & (mem_rd_q == id_rs1);
  assign mem_wr_b = mem_writes_any & (mem_rd_q == id_rs2);

  assign load_use_hazard = ex_writes_any & ex_mr_q & id_valid &
                           ((id_use_rs1 & ex_wr_a) | (id_use_rs2 & ex_wr_b));

  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_rd_d     = ex_rd_q;
    ex_rw_d     = ex_rw_q;
    ex_mr_d     = ex_mr_q;
    mem_valid_d = mem_valid_q;
    mem_rd_d    = mem_rd_q;
    mem_rw_d    = mem_rw_q;
    sel_a_d     = sel_a_q;
    sel_b_d     = sel_b_q;
    if (!stall) begin
      mem_valid_d = ex_valid_q;
      mem_rd_d    = ex_rd_q;
      mem_rw_d    = ex_rw_q;
      if (flush || load_use_hazard) begin
        ex_valid_d = 1'b0;
        ex_rd_d    = '0;
        ex_rw_d    = 1'b0;
        ex_mr_d    = 1'b0;
        sel_a_d    = SEL_RF;
        sel_b_d    = SEL_RF;
      end else begin
        ex_valid_d = id_valid;
        ex_rd_d    = id_rd;
        ex_rw_d    = id_reg_write;
        ex_mr_d    = id_mem_read;
        // Youngest producer wins: EX (becomes EX/MEM) over MEM (becomes MEM/WB).
        sel_a_d = SEL_RF;
        if (id_valid && id_use_rs1) begin
          if (ex_wr_a)       sel_a_d = SEL_EX;
          else if (mem_wr_a) sel_a_d = SEL_MEM;
        end
        sel_b_d = SEL_RF;
        if (id_valid && id_use_rs2) begin
          if (ex_wr_b)       sel_b_d = SEL_EX;
          else if (mem_wr_b) sel_b_d = SEL_MEM;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_rd_q     <= '0;
      ex_rw_q     <= 1'b0;
      ex_mr_q     <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_rd_q    <= '0;
      mem_rw_q    <= 1'b0;
      sel_a_q     <= SEL_RF;
      sel_b_q     <= SEL_RF;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_rd_q     <= ex_rd_d;
      ex_rw_q     <= ex_rw_d;
      ex_mr_q     <= ex_mr_d;
      mem_valid_q <= mem_valid_d;
      mem_rd_q    <= mem_rd_d;
      mem_rw_q    <= mem_rw_d;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
    end
  end

  assign sel_a = sel_a_q;
  assign sel_b = sel_b_q;

endmodule

// File: doc/fwd_sel_gen.md
Name: fwd_sel_gen

Overview:
Sequential forwarding-control unit for the pipelined RISC-V core. It drives the 2-bit selection lines of the EX-stage operand 4-to-1 multiplexers (ALU source A and source B). It tracks destination-register tags of in-flight instructions through EX, MEM and WB. For each instruction entering EX it produces registered select codes, and it flags load-use hazards for the ID-stage stall logic.

Parameters:
REG_AW, 5, register-index width
SEL_W, 2, select-code width (matches 4-input operand mux)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
id_valid  input  1  instruction in ID is valid
id_rs1  input  REG_AW  ID source register 1
id_rs2  input  REG_AW  ID source register 2
id_use_rs1  input  1  ID instruction reads rs1
id_use_rs2  input  1  ID instruction reads rs2
id_rd  input  REG_AW  ID destination register
id_reg_write  input  1  ID instruction writes rd
id_mem_read  input  1  ID instruction is a load
stall  input  1  global freeze (e.g. memory wait)
flush  input  1  branch-taken flush of ID and EX
sel_a  output  SEL_W  registered select for EX operand A mux
sel_b  output  SEL_W  registered select for EX operand B mux
load_use_hazard  output  1  combinational; ID must hold, bubble goes into EX

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high (rst).
- Internal tag stages EX, MEM and WB. Each stage holds {valid, rd, reg_write, mem_read}.
- Reset:
  - all stage valids = 0
  - sel_a = sel_b = 2'b00
  - load_use_hazard = 0
- Select encoding:
  - 00 = register-file value
  - 01 = MEM/WB result
  - 10 = EX/MEM ALU result
  - 11 = reserved, never driven
- A stage "writes x" when valid & reg_write & rd == x & rd != 0.
- load_use_hazard = EX.valid & EX.mem_read & EX.reg_write & EX.rd != 0 & id_valid & ((id_use_rs1 & id_rs1 == EX.rd) | (id_use_rs2 & id_rs2 == EX.rd)).
- Advance on rising clk, priority order:
  1. rst: as above.
  2. stall = 1: all state and sel outputs hold. Has priority over flush and hazard.
  3. flush = 1:
     - WB <= MEM, MEM <= EX
     - EX <= bubble (valid = 0)
     - sel_a = sel_b = 00
  4. load_use_hazard = 1:
     - WB <= MEM, MEM <= EX
     - EX <= bubble, sel = 00
     - ID contents are held by the external pipeline and re-evaluated next cycle.
  5. Otherwise:
     - WB <= MEM, MEM <= EX
     - EX <= {id_valid, id_rd, id_reg_write, id_mem_read}
     - sel_a computed for id_rs1 (gated by id_use_rs1), sel_b for id_rs2 (gated by id_use_rs2), both against pre-edge state:
       - 10 if current EX writes the source (it becomes EX/MEM)
       - else 01 if current MEM writes the source (it becomes MEM/WB)
       - else 00
- Priority: the youngest producer wins (10 over 01).
- x0 never forwards.
- Latency: select codes are valid in the same cycle the consumer occupies EX (registered, 1 cycle after ID).
- WB-stage producers are not forwarded; the register file writes on the first half-cycle (write-through).
- Unused source (use = 0) yields select 00 regardless of tag match.
- Invalid ID instruction (id_valid = 0) enters EX as a bubble with sel = 00.
- After a hazard bubble, the re-presented consumer sees the load in MEM and receives select 01.
- rst asserted mid-operation clears everything on that edge, with no partial shift.

Test Plan:
- Reset: rst = 1 for 2 cycles with random inputs -> sel_a = sel_b = 00, load_use_hazard = 0.
- EX-EX forward: "add x5" (reg_write) then "sub x6, x5, x7" back-to-back -> sel_a = 10, sel_b = 00 while sub is in EX.
- MEM-EX forward and priority:
  - "add x5", nop, "or x8, x1, x5" -> sel_b = 01.
  - "add x5", "addi x5", "or x8, x5, x5" -> sel_a = sel_b = 10 (youngest wins).
- Load-use: "lw x9" then "add x3, x9, x2":
  - load_use_hazard = 1 for exactly one cycle
  - bubble in EX with sel = 00
  - next cycle the add sees sel_a = 01
- x0 and unused operand:
  - "addi x0" then "add x4, x0, x0" -> sel = 00
  - "lui x7" then an instruction with id_use_rs2 = 0 and id_rs2 = 7 -> sel_b = 00
- Stall/flush:
  - stall held 3 cycles mid-sequence -> sel and hazard unchanged, forwarding after release as if no stall
  - flush with a producer in EX -> next EX has sel = 00; the producer still forwards 01 to an instruction two slots later
